// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, LSB first, one bit per clock with start/busy/done handshake.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0] cnt;
    logic br, x, y, d, br_nxt, last;
    always_comb begin
        x      = a_sh[0];
        y      = b_sh[0];
        d      = x ^ y ^ br;
        br_nxt = (~x & y) | (~(x ^ y) & br);
        last   = cnt == CW'(WIDTH - 1);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_comb
        state_nxt = (state == IDLE && start) ? RUN  :
                    (state == RUN && last)   ? DONE :
                    (state == DONE)          ? IDLE : state;
    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= {d, r_sh[WIDTH-1:1]};
            br   <= br_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
                diff   <= {d, r_sh[WIDTH-1:1]};
                borrow <= br_nxt;
            end
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=8 and WIDTH=13.
module tb_serial_sub;
    logic clk = 0, rst_n = 0, start = 0, start13 = 0;
    logic [7:0] a = 0, b = 0, diff;
    logic [12:0] a13 = 0, b13 = 0, diff13;
    logic busy, done, borrow, busy13, done13, borrow13;
    int errors = 0, checks = 0;
    logic [8:0] q8[$];
    logic [13:0] q13[$];

    serial_sub #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow));
    serial_sub #(.WIDTH(13)) u13 (.clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
        .busy(busy13), .done(done13), .diff(diff13), .borrow(borrow13));

    always #5 clk = ~clk;

    task automatic do_op8(input logic [7:0] x, input logic [7:0] y, output logic [8:0] got,
                          output int busy_cycles, output bit seen);
        @(negedge clk);
        a = x; b = y; start = 1;
        q8.push_back({1'b0, x} - {1'b0, y});
        @(posedge clk);
        #1 start = 0; a = 8'($urandom); b = 8'($urandom);
        busy_cycles = 0; seen = 0; got = 'x;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; got = {borrow, diff}; end
            else if (busy) busy_cycles++;
        end
    endtask

    task automatic do_op13(input logic [12:0] x, input logic [12:0] y, output logic [13:0] got,
                           output bit seen);
        @(negedge clk);
        a13 = x; b13 = y; start13 = 1;
        q13.push_back({1'b0, x} - {1'b0, y});
        @(posedge clk);
        #1 start13 = 0; a13 = 13'($urandom); b13 = 13'($urandom);
        seen = 0; got = 'x;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done13) begin seen = 1; got = {borrow13, diff13}; end
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        @(negedge clk);
        checks++;
        if ({busy, done, borrow, diff} !== 11'd0) begin
            errors++; $display("FAIL reset8 got=%h want=0", {busy, done, borrow, diff});
        end
        checks++;
        if ({busy13, done13, borrow13, diff13} !== 16'd0) begin
            errors++; $display("FAIL reset13 got=%h want=0", {busy13, done13, borrow13, diff13});
        end
        rst_n = 1;
    endtask

    task automatic test_basic;
        logic [8:0] got, exp;
        int bc;
        bit seen;
        do_op8(8'd100, 8'd37, got, bc, seen);
        exp = q8.pop_front();
        checks++;
        if (!seen) begin errors++; $display("FAIL basic_timeout got=no_done want=done"); end
        checks++;
        if (got !== exp) begin errors++; $display("FAIL basic_result got=%0d want=%0d", got, exp); end
        checks++;
        if (bc != 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=8", bc); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b want=0", done); end
    endtask

    task automatic test_corners;
        logic [7:0] ta[4] = '{8'd5, 8'd0, 8'd255, 8'd0};
        logic [7:0] tb[4] = '{8'd9, 8'd255, 8'd0, 8'd0};
        logic [8:0] got, exp;
        int bc;
        bit seen;
        for (int i = 0; i < 4; i++) begin
            do_op8(ta[i], tb[i], got, bc, seen);
            exp = q8.pop_front();
            checks++;
            if (!seen || got !== exp) begin
                errors++; $display("FAIL corner%0d got=%0d want=%0d", i, got, exp);
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [8:0] got, exp;
        int bc;
        bit seen, held;
        do_op8(8'd200, 8'd1, got, bc, seen);
        exp = q8.pop_front();
        checks++;
        if (!seen || got !== exp) begin errors++; $display("FAIL ignore_pre got=%0d want=%0d", got, exp); end
        @(negedge clk);
        a = 8'd10; b = 8'd3; start = 1;
        q8.push_back(9'd7);
        @(posedge clk);
        #1 a = 8'd1; b = 8'd1;
        seen = 0; held = 1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1; got = {borrow, diff}; start = 0;
            end else begin
                if ({borrow, diff} !== 9'd199) held = 0;
                a = 8'($urandom); b = 8'($urandom);
            end
        end
        start = 0;
        exp = q8.pop_front();
        checks++;
        if (!held) begin errors++; $display("FAIL ignore_hold got=changed want=199"); end
        checks++;
        if (!seen || got !== exp) begin errors++; $display("FAIL ignore_result got=%0d want=%0d", got, exp); end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_requeue got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [8:0] exp;
        int ndone = 0, last_t = -1;
        @(negedge clk);
        a = 8'd200; b = 8'd100; start = 1;
        repeat (3) q8.push_back(9'd100);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (busy && done) begin errors++; $display("FAIL b2b_overlap cycle=%0d got=11 want=not_both", i); end
            if (done) begin
                exp = q8.pop_front();
                checks++;
                if ({borrow, diff} !== exp) begin
                    errors++; $display("FAIL b2b_result got=%0d want=%0d", {borrow, diff}, exp);
                end
                if (last_t >= 0) begin
                    checks++;
                    if (i - last_t != 10) begin errors++; $display("FAIL b2b_period got=%0d want=10", i - last_t); end
                end
                last_t = i;
                ndone++;
            end
        end
        start = 0;
        checks++;
        if (ndone != 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", ndone); end
        q8.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        logic [8:0] got, exp;
        int bc;
        bit seen, quiet;
        @(negedge clk);
        a = 8'd77; b = 8'd11; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        #1;
        checks++;
        if ({busy, done, borrow, diff} !== 11'd0) begin
            errors++; $display("FAIL midrun_reset got=%h want=0", {busy, done, borrow, diff});
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        quiet = 1;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) quiet = 0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL midrun_ghost got=activity want=idle"); end
        do_op8(8'd77, 8'd11, got, bc, seen);
        exp = q8.pop_front();
        checks++;
        if (!seen || got !== exp) begin errors++; $display("FAIL midrun_after got=%0d want=%0d", got, exp); end
    endtask

    task automatic test_random;
        logic [8:0] got, exp;
        logic [13:0] got13, exp13;
        int bc, bad = 0, bad13 = 0;
        bit seen;
        for (int i = 0; i < 1000; i++) begin
            do_op8(8'($urandom), 8'($urandom), got, bc, seen);
            exp = q8.pop_front();
            checks++;
            if (!seen || got !== exp || bc != 8) begin
                errors++;
                if (bad++ < 5) $display("FAIL rand8 got=%0d want=%0d busy=%0d", got, exp, bc);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            do_op13(13'($urandom), 13'($urandom), got13, seen);
            exp13 = q13.pop_front();
            checks++;
            if (!seen || got13 !== exp13) begin
                errors++;
                if (bad13++ < 5) $display("FAIL rand13 got=%0d want=%0d", got13, exp13);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
